// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the registered 8-bit ALU:
//   WIDTH    - datapath width (fixed at 8)
//   alu_op_t - operation select encoding (add, subtract, xor, left shift)
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int WIDTH = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_XOR = 2'd2,
        OP_SHL = 2'd3
    } alu_op_t;

endpackage : alu_pkg

// File: rtl/alu_adder8.sv
// ----------------------------------------------------------------------------
// alu_adder8
// Purely combinational 8-bit ripple-carry adder.
// Ports:
//   a, b  (in,  8 bits) - addends
//   cin   (in,  1 bit)  - carry in
//   s     (out, 8 bits) - low 8 bits of a + b + cin
//   cout  (out, 1 bit)  - carry out of bit 7
// ----------------------------------------------------------------------------
module alu_adder8
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    // carry[i] is the carry into bit i; carry[WIDTH] leaves the adder.
    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_full_adder
            assign s[gi]         = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[WIDTH];

endmodule : alu_adder8

// File: rtl/alu.sv
// ----------------------------------------------------------------------------
// alu
// Registered 8-bit ALU, one-cycle latency. Every clock, only the result
// group selected by `operation` loads; all other groups hold.
// Ports:
//   clk               (in)      rising-edge clock
//   rst_n             (in)      asynchronous active-low reset, clears outputs
//   a, b              (in,  8)  unsigned operands
//   operation         (in,  2)  0 add, 1 subtract, 2 xor, 3 left shift of a
//   sum, cout         (out, 8/1) a + b as a 9-bit result
//   difference, bout  (out, 8/1) a - b mod 256, borrow (a < b)
//   xor_output        (out, 8)  a ^ b
//   left_shift_output (out, 8)  {a[6:0], 1'b0}
// ----------------------------------------------------------------------------
module alu
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       operation,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] difference,
    output logic             bout,
    output logic [WIDTH-1:0] xor_output,
    output logic [WIDTH-1:0] left_shift_output
);

    // ---------------- combinational results ----------------
    logic [WIDTH-1:0] add_s;
    logic             add_c;
    logic [WIDTH-1:0] sub_s;
    logic             sub_c;
    logic [WIDTH-1:0] xor_next;
    logic [WIDTH-1:0] shl_next;

    alu_adder8 u_add (
        .a    (a),
        .b    (b),
        .cin  (1'b0),
        .s    (add_s),
        .cout (add_c)
    );

    // Two's-complement subtract: a + ~b + 1. A carry out means no borrow.
    alu_adder8 u_sub (
        .a    (a),
        .b    (~b),
        .cin  (1'b1),
        .s    (sub_s),
        .cout (sub_c)
    );

    assign xor_next = a ^ b;
    assign shl_next = {a[WIDTH-2:0], 1'b0};

    // ---------------- load enables ----------------
    alu_op_t op;
    logic    add_en;
    logic    sub_en;
    logic    xor_en;
    logic    shl_en;

    assign op = alu_op_t'(operation);

    always_comb begin
        add_en = 1'b0;
        sub_en = 1'b0;
        xor_en = 1'b0;
        shl_en = 1'b0;
        case (op)
            OP_ADD:  add_en = 1'b1;
            OP_SUB:  sub_en = 1'b1;
            OP_XOR:  xor_en = 1'b1;
            OP_SHL:  shl_en = 1'b1;
            default: ;
        endcase
    end

    // ---------------- output registers ----------------
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             bout_reg;
    logic [WIDTH-1:0] xor_reg;
    logic [WIDTH-1:0] shl_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg  <= '0;
            cout_reg <= 1'b0;
        end else if (add_en) begin
            sum_reg  <= add_s;
            cout_reg <= add_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_reg <= '0;
            bout_reg <= 1'b0;
        end else if (sub_en) begin
            diff_reg <= sub_s;
            bout_reg <= ~sub_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xor_reg <= '0;
        end else if (xor_en) begin
            xor_reg <= xor_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shl_reg <= '0;
        end else if (shl_en) begin
            shl_reg <= shl_next;
        end
    end

    assign sum               = sum_reg;
    assign cout              = cout_reg;
    assign difference        = diff_reg;
    assign bout              = bout_reg;
    assign xor_output        = xor_reg;
    assign left_shift_output = shl_reg;

endmodule : alu

// File: tb/tb_alu.sv
// ----------------------------------------------------------------------------
// tb_alu
// Self-checking bench for alu: an arithmetic reference model updated on each
// rising edge, a compare process on every falling edge, plus literal checks
// of the hand-computed cases.
// ----------------------------------------------------------------------------
module tb_alu;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] operation;
    logic [7:0] sum;
    logic       cout;
    logic [7:0] difference;
    logic       bout;
    logic [7:0] xor_output;
    logic [7:0] left_shift_output;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    alu dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .a                 (a),
        .b                 (b),
        .operation         (operation),
        .sum               (sum),
        .cout              (cout),
        .difference        (difference),
        .bout              (bout),
        .xor_output        (xor_output),
        .left_shift_output (left_shift_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_sum, m_cout, m_diff, m_bout, m_xor, m_shl;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sum = 0; m_cout = 0; m_diff = 0; m_bout = 0; m_xor = 0; m_shl = 0;
        end else begin
            int ia, ib;
            ia = int'(a);
            ib = int'(b);
            case (operation)
                2'd0: begin
                    m_sum  = (ia + ib) % 256;
                    m_cout = (ia + ib > 255) ? 1 : 0;
                end
                2'd1: begin
                    m_diff = (ia - ib + 256) % 256;
                    m_bout = (ia < ib) ? 1 : 0;
                end
                2'd2: m_xor = ia ^ ib;
                default: m_shl = (ia * 2) % 256;
            endcase
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            check("sum",  int'(sum),               m_sum);
            check("cout", int'(cout),              m_cout);
            check("diff", int'(difference),        m_diff);
            check("bout", int'(bout),              m_bout);
            check("xor",  int'(xor_output),        m_xor);
            check("shl",  int'(left_shift_output), m_shl);
        end
    end

    // Drive one operation at the falling edge; results are valid after the next rising edge.
    task automatic apply(input logic [7:0] ta, input logic [7:0] tb_, input logic [1:0] top);
        @(negedge clk);
        a = ta;
        b = tb_;
        operation = top;
        @(posedge clk);
        #1;
        $display("op=%0d a=%0d b=%0d -> sum=%0d cout=%0d diff=%0d bout=%0d xor=%0d shl=%0d",
                 top, ta, tb_, sum, cout, difference, bout, xor_output, left_shift_output);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sum"},  int'(sum),               0);
        check({tag, "_cout"}, int'(cout),              0);
        check({tag, "_diff"}, int'(difference),        0);
        check({tag, "_bout"}, int'(bout),              0);
        check({tag, "_xor"},  int'(xor_output),        0);
        check({tag, "_shl"},  int'(left_shift_output), 0);
    endtask

    initial begin
        rst_n = 1'b1;
        a = 8'd0; b = 8'd0; operation = 2'd0;
        #1 rst_n = 1'b0;

        // Reset held with random inputs and running clock
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 8'($urandom); b = 8'($urandom); operation = 2'($urandom);
        end
        cmp_en = 1;
        @(posedge clk);
        #1 check_all_zero("rst_hold");

        @(negedge clk);
        rst_n = 1'b1;

        // Add
        apply(8'd135, 8'd24, 2'd0);
        check("add1_sum", int'(sum), 159);
        check("add1_cout", int'(cout), 0);
        apply(8'd193, 8'd205, 2'd0);
        check("add2_sum", int'(sum), 142);
        check("add2_cout", int'(cout), 1);

        // Subtract
        apply(8'd34, 8'd84, 2'd1);
        check("sub1_diff", int'(difference), 206);
        check("sub1_bout", int'(bout), 1);
        apply(8'd216, 8'd94, 2'd1);
        check("sub2_diff", int'(difference), 122);
        check("sub2_bout", int'(bout), 0);

        // XOR and shift
        apply(8'd53, 8'd98, 2'd2);
        check("xor1", int'(xor_output), 87);
        apply(8'd241, 8'($urandom), 2'd3);
        check("shl1", int'(left_shift_output), 226);

        // Hold behaviour
        apply(8'd57, 8'd48, 2'd0);
        check("hold_sum0", int'(sum), 105);
        apply(8'd235, 8'd123, 2'd2);
        check("hold_xor", int'(xor_output), 144);
        check("hold_sum", int'(sum), 105);
        check("hold_diff", int'(difference), 122);
        check("hold_shl", int'(left_shift_output), 226);

        // Boundary operands
        apply(8'd255, 8'd1, 2'd0);
        check("add_wrap_sum", int'(sum), 0);
        check("add_wrap_cout", int'(cout), 1);
        apply(8'd77, 8'd77, 2'd1);
        check("sub_eq_diff", int'(difference), 0);
        check("sub_eq_bout", int'(bout), 0);

        // Random regression
        for (int i = 0; i < 40; i++)
            apply(8'($urandom), 8'($urandom), 2'($urandom_range(3, 0)));

        // Asynchronous reset mid-cycle must clear immediately
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_async");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++)
            apply(8'($urandom), 8'($urandom), 2'($urandom_range(3, 0)));

        @(negedge clk);
        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_alu
